// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rxfilt_1_pkg.sv
// Shared definitions for the rxfilt receive-conditioning cell: filter state
// encodings, legal parameter ranges and the filter counter width.
package gf180mcu_fd_sc_mcu9t5v0__rxfilt_1_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    PEND   = 1'b1
  } filt_state_e;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
  localparam int FILT_MIN = 1;
  localparam int FILT_MAX = 255;

  // clog2 of the filter length, never narrower than one bit.
  function automatic int cnt_width(input int filt_cycles);
    return (filt_cycles <= 2) ? 1 : $clog2(filt_cycles);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rxfilt_1_func.sv
// Behavioral core of rxfilt: input synchronizer, pulse-width filter FSM and
// rise/fall strobes. All sequential state of the cell lives here.
module gf180mcu_fd_sc_mcu9t5v0__rxfilt_1_func
  import gf180mcu_fd_sc_mcu9t5v0__rxfilt_1_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYCLES = 4,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                I,
  output logic                                Z,
  output logic                                ZR,
  output logic                                ZF,
  output filt_state_e                         state,
  output logic [cnt_width(FILT_CYCLES)-1:0]   cnt
);

  localparam int CW = cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("rxfilt: SYNC_STAGES=%0d outside %0d..%0d", SYNC_STAGES, SYNC_MIN, SYNC_MAX);
  end
  if (FILT_CYCLES < FILT_MIN || FILT_CYCLES > FILT_MAX) begin : g_bad_filt
    $error("rxfilt: FILT_CYCLES=%0d outside %0d..%0d", FILT_CYCLES, FILT_MIN, FILT_MAX);
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  filt_state_e            state_d;
  logic [CW-1:0]          cnt_d;
  logic                   z_d;
  logic                   zr_d;
  logic                   zf_d;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync  <= {SYNC_STAGES{RESET_VAL}};
      state <= STABLE;
      cnt   <= '0;
      Z     <= RESET_VAL;
      ZR    <= 1'b0;
      ZF    <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], I};
      state <= state_d;
      cnt   <= cnt_d;
      Z     <= z_d;
      ZR    <= zr_d;
      ZF    <= zf_d;
    end
  end

  // Any cycle where S agrees with Z drops a pending change (glitch rejection).
  always_comb begin
    state_d = STABLE;
    cnt_d   = '0;
    z_d     = Z;
    zr_d    = 1'b0;
    zf_d    = 1'b0;
    if (s != Z) begin
      if (cnt == CNT_LAST) begin
        z_d  = s;
        zr_d = s;
        zf_d = ~s;
      end else begin
        state_d = PEND;
        cnt_d   = cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rxfilt_1.sv
// rxfilt standard cell: synchronizes and deglitches an asynchronous line,
// driving a clean level Z plus one-cycle rise/fall strobes.
module gf180mcu_fd_sc_mcu9t5v0__rxfilt_1
  import gf180mcu_fd_sc_mcu9t5v0__rxfilt_1_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYCLES = 4,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic I,
  output logic Z,
  output logic ZR,
  output logic ZF,
  inout  wire  VDD,
  inout  wire  VSS
);

  // Supplies carry no logic function.
  wire unused_supply = VDD ^ VSS;

  filt_state_e                             unused_state;
  logic [cnt_width(FILT_CYCLES)-1:0]       unused_cnt;

`ifdef FUNCTIONAL
  gf180mcu_fd_sc_mcu9t5v0__rxfilt_1_func #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYCLES (FILT_CYCLES),
    .RESET_VAL   (RESET_VAL)
  ) u_func (
    .CLK   (CLK),
    .RST   (RST),
    .I     (I),
    .Z     (Z),
    .ZR    (ZR),
    .ZF    (ZF),
    .state (unused_state),
    .cnt   (unused_cnt)
  );
`else
  gf180mcu_fd_sc_mcu9t5v0__rxfilt_1_func #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYCLES (FILT_CYCLES),
    .RESET_VAL   (RESET_VAL)
  ) u_func (
    .CLK   (CLK),
    .RST   (RST),
    .I     (I),
    .Z     (Z),
    .ZR    (ZR),
    .ZF    (ZF),
    .state (unused_state),
    .cnt   (unused_cnt)
  );

  // I is asynchronous by definition, so it carries no setup/hold check.
  specify
    (posedge CLK => Z)  = (1.0, 1.0);
    (posedge CLK => ZR) = (1.0, 1.0);
    (posedge CLK => ZF) = (1.0, 1.0);
    (posedge RST => Z)  = (1.0, 1.0);
    (posedge RST => ZR) = (1.0, 1.0);
    (posedge RST => ZF) = (1.0, 1.0);
    $recovery(negedge RST, posedge CLK, 1.0);
    $removal(negedge RST, posedge CLK, 1.0);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rxfilt_1.sv
// Directed bench for rxfilt: defaults, FILT_CYCLES=1 and FILT_CYCLES=255/SYNC_STAGES=4.
module tb_gf180mcu_fd_sc_mcu9t5v0__rxfilt_1;
  import gf180mcu_fd_sc_mcu9t5v0__rxfilt_1_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_a = 1'b0, i_b = 1'b0, i_c = 1'b0;
  logic z_a, zr_a, zf_a;
  logic z_b, zr_b, zf_b;
  logic z_c, zr_c, zf_c;
  wire  vdd = 1'b1;
  wire  vss = 1'b0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__rxfilt_1 dut (
    .CLK(clk), .RST(rst), .I(i_a), .Z(z_a), .ZR(zr_a), .ZF(zf_a), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu9t5v0__rxfilt_1 #(.SYNC_STAGES(2), .FILT_CYCLES(1)) dut1 (
    .CLK(clk), .RST(rst), .I(i_b), .Z(z_b), .ZR(zr_b), .ZF(zf_b), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu9t5v0__rxfilt_1 #(.SYNC_STAGES(4), .FILT_CYCLES(255)) dut255 (
    .CLK(clk), .RST(rst), .I(i_c), .Z(z_c), .ZR(zr_c), .ZF(zf_c), .VDD(vdd), .VSS(vss)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic       seen;
  logic [7:0] maxcnt;

  initial begin
    // Reset state, no clock edge yet
    #3;
    chk("rst_z", z_a, 0);
    chk("rst_zr", zr_a, 0);
    chk("rst_zf", zf_a, 0);
    @(negedge clk) rst = 1'b0;

    // Latency with defaults, rising then falling
    @(negedge clk) i_a = 1'b1;
    edges(5);
    chk("lat_r_e5_z", z_a, 0);
    edges(1);
    chk("lat_r_e6_z", z_a, 1);
    chk("lat_r_e6_zr", zr_a, 1);
    chk("lat_r_e6_zf", zf_a, 0);
    edges(1);
    chk("lat_r_e7_zr", zr_a, 0);
    @(negedge clk) i_a = 1'b0;
    edges(5);
    chk("lat_f_e5_z", z_a, 1);
    edges(1);
    chk("lat_f_e6_z", z_a, 0);
    chk("lat_f_e6_zf", zf_a, 1);
    chk("lat_f_e6_zr", zr_a, 0);
    edges(1);
    chk("lat_f_e7_zf", zf_a, 0);

    // Asynchronous reset mid-cycle with Z high and I=1
    @(negedge clk) i_a = 1'b1;
    edges(7);
    chk("pre_rst_z", z_a, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_z", z_a, 0);
    chk("async_rst_zr", zr_a, 0);
    chk("async_rst_zf", zf_a, 0);
    @(negedge clk) rst = 1'b0;
    edges(5);
    chk("post_rst_e5_z", z_a, 0);
    edges(1);
    chk("post_rst_e6_z", z_a, 1);
    chk("post_rst_e6_zr", zr_a, 1);
    edges(1);
    chk("post_rst_e7_zr", zr_a, 0);
    @(negedge clk) i_a = 1'b0;
    edges(6);
    chk("back_low_z", z_a, 0);
    edges(2);

    // 3-cycle pulse rejected
    @(negedge clk) i_a = 1'b1;
    edges(3);
    @(negedge clk) i_a = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      edges(1);
      seen = seen | z_a | zr_a | zf_a;
    end
    chk("glitch3_quiet", seen, 0);

    // 4-cycle pulse passes: Z high edges 6..9
    @(negedge clk) i_a = 1'b1;
    edges(4);
    @(negedge clk) i_a = 1'b0;
    edges(1);
    chk("pulse4_e5_z", z_a, 0);
    edges(1);
    chk("pulse4_e6_z", z_a, 1);
    chk("pulse4_e6_zr", zr_a, 1);
    edges(3);
    chk("pulse4_e9_z", z_a, 1);
    chk("pulse4_e9_zf", zf_a, 0);
    edges(1);
    chk("pulse4_e10_z", z_a, 0);
    chk("pulse4_e10_zf", zf_a, 1);
    edges(3);

    // Retrigger: toggle every 2 cycles for 40 cycles
    seen   = 1'b0;
    maxcnt = 8'd0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk) i_a = ~i_a;
      for (int m = 0; m < 2; m++) begin
        edges(1);
        seen = seen | z_a | zr_a | zf_a;
        if (8'(dut.u_func.cnt) > maxcnt) maxcnt = 8'(dut.u_func.cnt);
      end
    end
    for (int m = 0; m < 4; m++) begin
      edges(1);
      seen = seen | z_a | zr_a | zf_a;
    end
    chk("retrig_quiet", seen, 0);
    chk("retrig_maxcnt", maxcnt, 2);
    @(negedge clk) i_a = 1'b1;
    edges(5);
    chk("retrig_hold_e5_z", z_a, 0);
    edges(1);
    chk("retrig_hold_e6_z", z_a, 1);
    chk("retrig_hold_e6_zr", zr_a, 1);

    // FILT_CYCLES=1: 3-edge delay, single-cycle pulses pass
    @(negedge clk) i_b = 1'b1;
    edges(2);
    chk("f1_e2_z", z_b, 0);
    edges(1);
    chk("f1_e3_z", z_b, 1);
    chk("f1_e3_zr", zr_b, 1);
    @(negedge clk) i_b = 1'b0;
    edges(1);
    @(negedge clk) i_b = 1'b1;
    edges(1);
    chk("f1_pulse_e2_z", z_b, 1);
    edges(1);
    chk("f1_pulse_e3_z", z_b, 0);
    chk("f1_pulse_e3_zf", zf_b, 1);
    edges(1);
    chk("f1_pulse_e4_z", z_b, 1);
    chk("f1_pulse_e4_zr", zr_b, 1);

    // FILT_CYCLES=255, SYNC_STAGES=4: edge 259, 254-cycle pulse rejected
    @(negedge clk) i_c = 1'b1;
    edges(258);
    chk("f255_e258_z", z_c, 0);
    edges(1);
    chk("f255_e259_z", z_c, 1);
    chk("f255_e259_zr", zr_c, 1);
    edges(2);
    @(negedge clk) i_c = 1'b0;
    edges(254);
    @(negedge clk) i_c = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 270; k++) begin
      edges(1);
      seen = seen | ~z_c | zr_c | zf_c;
    end
    chk("f255_pulse254_rejected", seen, 0);

    // Reset during PEND on default instance
    @(negedge clk) i_a = 1'b0;
    edges(8);
    chk("pend_pre_z", z_a, 0);
    @(negedge clk) i_a = 1'b1;
    edges(5);
    chk("pend_cnt", 8'(dut.u_func.cnt), 3);
    chk("pend_state", dut.u_func.state, PEND);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("pend_rst_z", z_a, 0);
    chk("pend_rst_cnt", 8'(dut.u_func.cnt), 0);
    chk("pend_rst_state", dut.u_func.state, STABLE);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      edges(1);
      seen = seen | z_a | zr_a | zf_a;
    end
    chk("pend_no_early", seen, 0);
    edges(1);
    chk("pend_full_e6_z", z_a, 1);
    chk("pend_full_e6_zr", zr_a, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
